fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Read-side consumer of the async FIFO; runs entirely in the read clock domain.
- Pops bytes through the FIFO's read interface (signal_read/empty/read_data) and packs BYTES consecutive bytes into one word.
- Presents each word on a valid/ready output port; a flush input emits a partial word.
- Sits between the FIFO read port and any word-wide downstream logic.

Parameters:
DATA_W, 8, width of one FIFO entry; must equal the FIFO data width
BYTES, 4, entries packed per output word; legal range 2..8
CNT_W, 4, width of out_count; must hold the value BYTES

Ports:
rclk  input  1  read-domain clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
empty  input  1  FIFO empty flag (read domain)
read_data  input  DATA_W  FIFO read data; valid in the cycle after an accepted pop
signal_read  output  1  pop request to the FIFO
flush  input  1  level; requests emission of a partial word
out_data  output  DATA_W*BYTES  packed word; first-popped entry in bits [DATA_W-1:0]
out_count  output  CNT_W  number of valid entries in out_data (1..BYTES)
out_valid  output  1  out_data/out_count valid
out_ready  input  1  downstream accepts the word

Behaviour:
- Reset, sampled at posedge rclk with rst=1, overrides all other inputs:
  - state=S_READ, lane counter=0, out_data=0, out_count=0, out_valid=0.
  - signal_read=0 while rst=1.
  - A reset mid-word discards the partial word; no word is emitted for it.
- FIFO pop contract:
  - A pop is accepted at a posedge where signal_read=1 and empty=0.
  - The popped entry appears on read_data during the next cycle and is latched at the following posedge.
  - signal_read is combinational: signal_read = (state==S_READ) && !empty && !flush_take.
  - flush_take = flush && (lane>0).
  - signal_read is never 1 while empty=1.
- States:
  - S_READ:
    - If flush_take, go to S_HOLD with out_count=lane; no pop that cycle.
    - Else if !empty, pop and go to S_CAPT.
    - Else remain in S_READ.
    - flush with lane=0 is ignored; no zero-length word is ever produced.
  - S_CAPT:
    - Latch read_data into lane slot: out_data[lane*DATA_W +: DATA_W].
    - lane increments.
    - If lane was BYTES-1, go to S_HOLD with out_count=BYTES; else go to S_READ.
    - flush is ignored in S_CAPT and takes effect in the following S_READ cycle.
  - S_HOLD:
    - out_valid=1; out_data and out_count are stable.
    - On out_ready=1: the word transfers, and at that posedge out_valid clears, lane=0, out_data clears to 0, state returns to S_READ.
    - No pops occur while in S_HOLD; FIFO backpressure builds naturally.
- Throughput and latency:
  - One entry per 2 rclk cycles; one idle cycle per word for the handshake.
  - Minimum latency from first pop to out_valid is 2*BYTES cycles.
- Slot rules:
  - Unfilled slots of a flushed word read as 0.
  - Lane arithmetic is unsigned; lane never exceeds BYTES-1 when writing a slot.
- Timing rules:
  - out_valid, out_data and out_count are registered.
  - out_valid, once raised, is held until out_ready; it never drops on its own.
  - out_ready while out_valid=0 has no effect.
  - empty rising between a pop and its capture has no effect; the accepted pop is always captured.

Test Plan:
- Reset, then FIFO delivers 0x11,0x22,0x33,0x44 with out_ready=1 -> one word out_data=0x44332211, out_count=4, out_valid high exactly 1 cycle; exactly 4 pops.
- Same data with out_ready=0 for 10 cycles, then 1 -> out_valid held 10+ cycles with out_data stable at 0x44332211; signal_read=0 throughout the hold; FIFO keeps its remaining entries.
- Push 0xAA,0xBB, wait until both captured, assert flush -> out_data=0x0000BBAA, out_count=2; next word starts at lane 0.
- FIFO empty with flush=1 and lane=0 for 20 cycles -> signal_read=0 and out_valid=0 throughout.
- Feed 9 entries 1..9 back-to-back, out_ready=1 -> words 0x04030201 then 0x08070605 (count 4); entry 9 stays pending in lane 0 until flush, which yields 0x00000009, count 1.
- Pop 3 entries, assert rst for 1 cycle, then feed 0x55,0x66,0x77,0x88 -> partial word discarded; first word is 0x88776655, count 4.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Read-domain consumer of the async FIFO: pops DATA_W-bit entries and packs BYTES
// of them (first popped in the low lane) into a word offered on a valid/ready port.
module fifo_word_packer #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 4
) (
    input  logic                      rclk,
    input  logic                      rst,
    input  logic                      empty,
    input  logic [DATA_W-1:0]         read_data,
    output logic                      signal_read,
    input  logic                      flush,
    output logic [DATA_W*BYTES-1:0]   out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_valid,
    input  logic                      out_ready
);

    generate
        if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
            $error("fifo_word_packer: BYTES must be in 2..8");
        end
        if ((BYTES >> CNT_W) != 0) begin : g_bad_cnt_w
            $error("fifo_word_packer: CNT_W too narrow to hold BYTES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_READ = 2'd0,
        S_CAPT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BYTES);

    state_t           state_reg;
    logic [CNT_W-1:0] lane_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_valid_reg;
    logic             flush_take;
    logic             word_taken;
    logic             capture;

    // A flush only counts once at least one entry sits in the word.
    assign flush_take  = flush && (lane_reg != '0);
    assign signal_read = !rst && (state_reg == S_READ) && !empty && !flush_take;
    assign word_taken  = (state_reg == S_HOLD) && out_ready;
    assign capture     = (state_reg == S_CAPT);

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_reg     <= S_READ;
            lane_reg      <= '0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_READ: begin
                    if (flush_take) begin
                        state_reg     <= S_HOLD;
                        out_count_reg <= lane_reg;
                        out_valid_reg <= 1'b1;
                    end else if (!empty) begin
                        state_reg <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    lane_reg <= lane_reg + 1'b1;
                    if (lane_reg == LAST_LANE) begin
                        state_reg     <= S_HOLD;
                        out_count_reg <= FULL_CNT;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= S_READ;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_reg     <= S_READ;
                        lane_reg      <= '0;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= S_READ;
                    lane_reg      <= '0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // One register per lane slot; slots clear on handoff so a flushed word has zero tails.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg;

            always_ff @(posedge rclk) begin
                if (rst || word_taken) begin
                    slot_reg <= '0;
                end else if (capture && (lane_reg == CNT_W'(gi))) begin
                    slot_reg <= read_data;
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = slot_reg;
        end
    endgenerate

    assign out_count = out_count_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural FIFO on the read port, scoreboard of
// expected words, table of word vectors plus hand sequences for hold/flush/reset.
module tb_fifo_word_packer;

    localparam int DATA_W = 8;
    localparam int BYTES  = 4;
    localparam int CNT_W  = 4;

    logic                    rclk = 1'b0;
    logic                    rst = 1'b1;
    logic                    empty = 1'b1;
    logic [DATA_W-1:0]       read_data = '0;
    logic                    signal_read;
    logic                    flush = 1'b0;
    logic [DATA_W*BYTES-1:0] out_data;
    logic [CNT_W-1:0]        out_count;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    always #5 rclk = ~rclk;

    fifo_word_packer #(.DATA_W(DATA_W), .BYTES(BYTES), .CNT_W(CNT_W)) dut (
        .rclk        (rclk),
        .rst         (rst),
        .empty       (empty),
        .read_data   (read_data),
        .signal_read (signal_read),
        .flush       (flush),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  count;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  b [4];
        bit          fl;
        logic [31:0] data;
        logic [3:0]  count;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] push_q[$];
    logic [7:0] fifo_q[$];
    int         vectors = 0;
    int         errors = 0;
    int         pops = 0;
    int         valid_cycles = 0;
    logic       hold_prev = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Behavioural FIFO: a pop accepted at this edge shows on read_data next cycle.
    always @(posedge rclk) begin
        logic [7:0] v;
        if (signal_read && !empty) begin
            v = fifo_q.pop_front();
            read_data <= v;
            pops++;
        end
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        empty <= (fifo_q.size() == 0);
    end

    always @(negedge rclk) begin
        exp_t e;
        if (signal_read) check("pop_while_empty", {31'd0, empty}, 32'd0);
        if (out_valid) valid_cycles++;
        if (hold_prev) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, prev_data);
            check("hold_no_pop", {31'd0, signal_read}, 32'd0);
        end
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h count %0d, required no word", out_data, out_count);
            end else begin
                e = exp_q.pop_front();
                $display("word data=0x%08h count=%0d (expect 0x%08h/%0d)", out_data, out_count, e.data, e.count);
                check("word_data", out_data, e.data);
                check("word_count", {28'd0, out_count}, {28'd0, e.count});
            end
        end
        hold_prev = out_valid && !out_ready && !rst;
        prev_data = out_data;
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        push_q.push_back(b);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] c);
        exp_t e;
        e.data  = d;
        e.count = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) tick();
        check("valid_arrives", {31'd0, out_valid}, 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        int p0;
        int v0;

        vecs[0] = '{n: 2, b: '{8'hAA, 8'hBB, 8'h00, 8'h00}, fl: 1'b1, data: 32'h0000BBAA, count: 4'd2};
        vecs[1] = '{n: 4, b: '{8'h01, 8'h02, 8'h03, 8'h04}, fl: 1'b0, data: 32'h04030201, count: 4'd4};
        vecs[2] = '{n: 4, b: '{8'h05, 8'h06, 8'h07, 8'h08}, fl: 1'b0, data: 32'h08070605, count: 4'd4};
        vecs[3] = '{n: 1, b: '{8'h09, 8'h00, 8'h00, 8'h00}, fl: 1'b1, data: 32'h00000009, count: 4'd1};
        vecs[4] = '{n: 3, b: '{8'hDE, 8'hAD, 8'hBE, 8'h00}, fl: 1'b1, data: 32'h00BEADDE, count: 4'd3};
        vecs[5] = '{n: 4, b: '{8'hF0, 8'hE1, 8'hD2, 8'hC3}, fl: 1'b0, data: 32'hC3D2E1F0, count: 4'd4};

        // Reset holds off pops even with data waiting.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (3) tick();
        check("rst_signal_read", {31'd0, signal_read}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", {28'd0, out_count}, 32'd0);

        // Single word, ready high.
        p0 = pops;
        v0 = valid_cycles;
        expect_word(32'h44332211, 4'd4);
        out_ready = 1'b1;
        rst = 1'b0;
        wait_drain(100);
        repeat (3) tick();
        check("t1_valid_cycles", valid_cycles - v0, 32'd1);
        check("t1_pops", pops - p0, 32'd4);

        // Backpressure: word held, FIFO keeps the rest.
        out_ready = 1'b0;
        p0 = pops;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid(100);
        expect_word(32'h44332211, 4'd4);
        expect_word(32'h04030201, 4'd4);
        v0 = valid_cycles;
        repeat (10) tick();
        check("t2_held_10", {31'd0, (valid_cycles - v0) >= 10}, 32'd1);
        check("t2_fifo_kept", fifo_q.size(), 32'd4);
        check("t2_pops", pops - p0, 32'd4);
        out_ready = 1'b1;
        wait_drain(100);

        // Table of word vectors; flush records wait for all entries to be captured.
        foreach (vecs[k]) begin
            if (vecs[k].fl) wait_drain(100);
            for (int j = 0; j < vecs[k].n; j++) push(vecs[k].b[j]);
            if (vecs[k].fl) begin
                repeat (2 * vecs[k].n + 4) tick();
                check("pending_no_word", {31'd0, out_valid}, 32'd0);
                expect_word(vecs[k].data, vecs[k].count);
                flush = 1'b1;
                wait_valid(50);
                flush = 1'b0;
            end else begin
                expect_word(vecs[k].data, vecs[k].count);
            end
        end
        wait_drain(200);

        // Flush at lane 0 on an empty FIFO produces nothing.
        repeat (2) tick();
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_flush", {30'd0, signal_read, out_valid}, 32'd0);
        end
        flush = 1'b0;

        // Reset mid-word discards the partial word.
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (8) tick();
        check("mid_no_word", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        expect_word(32'h88776655, 4'd4);
        wait_drain(100);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
